sha256_work_dispatcher: RTL and testbench
=========================================

Name: sha256_work_dispatcher

Overview:
Feeds the unrolled SHA-256 hashing core and consumes its output. Accepts one work unit (midstate, 96-bit header tail, nonce range) and issues one nonce per clock into the core's rx_state/rx_data. Tracks in-flight nonces through a latency-matched valid delay line. Checks the core's tx_midhash against a match constant and returns the winning nonce over a valid/ready result handshake.

Parameters:
LATENCY, 248, clocks from hash_data/hash_state change to the matching hash_midhash value; must equal the instanced core's latency (>=2).
MATCH_VALUE, 32'hA41F32E7, hash_midhash value that flags a candidate nonce.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
work_valid  in  1  work unit offered
work_ready  out  1  dispatcher can accept work (IDLE only)
work_midstate  in  256  state words 0..7 to core
work_tail  in  96  header tail words 0..2
work_nonce_start  in  32  first nonce
work_nonce_end  in  32  last nonce, inclusive
hash_state  out  256  to core rx_state
hash_data  out  512  to core rx_data
hash_midhash  in  32  from core tx_midhash
result_valid  out  1  candidate nonce held
result_ready  in  1  consumer takes result
result_nonce  out  32  candidate nonce
result_overflow  out  1  sticky: a candidate was dropped
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (async assert, sync release): state IDLE; work_ready=1; busy=0; done=0; result_valid=0; result_nonce=0; result_overflow=0; hash_state=0; hash_data=0; delay line cleared. In-flight core results are ignored after reset.
- States: IDLE -> ISSUE on work_valid&&work_ready. ISSUE -> DRAIN in the cycle after the nonce equal to work_nonce_end is issued. DRAIN -> IDLE after LATENCY cycles; done=1 for exactly that transition cycle.
- Accept: latch midstate, tail, start, end. The issue counter loads start. The retire counter loads start.
- hash_data word map (word k = bits 32k+31:32k): words 0-2 = tail words 0-2; word 3 = issue counter; word 4 = 32'h80000000; words 5-14 = 0; word 15 = 32'h00000280. hash_state = latched midstate, held stable until the next accept.
- ISSUE: one nonce per cycle with no stalls. The valid bit entering the delay line is 1. The counter increments mod 2^32, so end < start wraps through FFFFFFFF->0. start==end issues exactly one nonce. start==end+1 sweeps all 2^32 nonces.
- Delay line: LATENCY-deep shift register of valid bits, shifted every cycle. A 0 is inserted in IDLE and DRAIN.
- Retire: when the bit leaving the delay line is 1, hash_midhash belongs to the retire counter's nonce. The retire counter then increments mod 2^32.
- Match: retiring valid && hash_midhash==MATCH_VALUE.
  - If result_valid=0, or result_ready=1 in the same cycle, result_nonce<=retire nonce and result_valid<=1.
  - Otherwise the candidate is dropped and result_overflow<=1.
- result_valid clears on result_ready with no simultaneous new match. result_overflow clears only on reset or on the next work accept.
- Results may still be presented after done; the consumer is not required to drain them before new work is accepted.

Optional Feature:
SHA256_DISPATCH_STATS_EN
- Defined: adds output stat_hashes (48 bits), reset 0. It increments on every retiring valid bit, does not clear on new work, and wraps at 2^48.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-ISSUE (start=0, LATENCY=8 behavioural core model) -> all outputs return to reset values immediately; no result_valid afterward even though the model still emits pipelined values.
- start=0x10, end=0x13, model returns MATCH_VALUE only for nonce 0x12 -> result_nonce=0x12 exactly LATENCY+3 cycles after the first issue cycle; done pulses once, LATENCY+4 cycles after the first issue cycle; hash_data word 15=0x280.
- start=0xFFFFFFFE, end=0x00000001 -> issued nonces FFFFFFFE, FFFFFFFF, 0, 1 in consecutive cycles; 4 retirements.
- Matches on consecutive nonces 5 and 6 with result_ready=0 -> result_nonce=5, result_overflow=1; with result_ready held 1, both delivered with no overflow.
- start=end=0x7 -> single issue, work_ready low until done, work_valid ignored while busy.
- STATS_EN: two jobs of 4 and 3 nonces -> stat_hashes=7.

Source files
------------

// File: rtl/sha256_work_dispatcher_if.sv
// rtl/sha256_work_dispatcher_if.sv - work-unit and result handshake bundle for the SHA-256 dispatcher
interface sha256_work_dispatcher_if;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_tail;
  logic [31:0]  work_nonce_start;
  logic [31:0]  work_nonce_end;
  logic         result_valid;
  logic         result_ready;
  logic [31:0]  result_nonce;
  logic         result_overflow;

  modport master (
    output work_valid, work_midstate, work_tail, work_nonce_start, work_nonce_end, result_ready,
    input  work_ready, result_valid, result_nonce, result_overflow
  );

  modport slave (
    input  work_valid, work_midstate, work_tail, work_nonce_start, work_nonce_end, result_ready,
    output work_ready, result_valid, result_nonce, result_overflow
  );
endinterface

// File: rtl/sha256_work_dispatcher.sv
// rtl/sha256_work_dispatcher.sv - issues one nonce per clock to the SHA-256 core and returns matching nonces
// Optional hash counter output stat_hashes enabled by defining SHA256_DISPATCH_STATS_EN.
module sha256_work_dispatcher #(
  parameter int unsigned LATENCY     = 248,
  parameter logic [31:0] MATCH_VALUE = 32'hA41F32E7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sha256_work_dispatcher_if.slave bus,
  output logic [255:0]            hash_state,
  output logic [511:0]            hash_data,
  input  logic [31:0]             hash_midhash,
  output logic                    busy,
  output logic                    done
`ifdef SHA256_DISPATCH_STATS_EN
  ,
  output logic [47:0]             stat_hashes
`endif
);

  localparam int unsigned DW = $clog2(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t             state, state_nx;
  logic [95:0]        tail_q;
  logic [31:0]        end_q;
  logic [31:0]        issue_cnt;
  logic [31:0]        retire_cnt;
  logic               pad_en;
  logic [LATENCY-1:0] dl;
  logic [DW-1:0]      drain_cnt;
  logic               dl_in;
  logic               accept;
  logic               drain_last;
  logic               retire;
  logic               match;
  logic               res_valid;
  logic [31:0]        res_nonce;
  logic               res_ovf;

  assign accept         = bus.work_valid && (state == S_IDLE);
  assign drain_last     = (state == S_DRAIN) && (drain_cnt == DW'(LATENCY - 1));
  assign retire         = dl[LATENCY-1];
  assign match          = retire && (hash_midhash == MATCH_VALUE);
  assign bus.work_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign bus.result_valid    = res_valid;
  assign bus.result_nonce    = res_nonce;
  assign bus.result_overflow = res_ovf;

  // Padding words only appear once a job has been loaded so the block is all-zero out of reset.
  assign hash_data = {pad_en ? 32'h00000280 : 32'h0, 320'b0,
                      pad_en ? 32'h80000000 : 32'h0, issue_cnt, tail_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dl_in    = 1'b0;
    case (state)
      S_IDLE:  if (bus.work_valid) state_nx = S_ISSUE;
      S_ISSUE: begin
        dl_in = 1'b1;
        if (issue_cnt == end_q) state_nx = S_DRAIN;
      end
      S_DRAIN: if (drain_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_state <= '0;
      tail_q     <= '0;
      end_q      <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      pad_en     <= 1'b0;
      dl         <= '0;
      drain_cnt  <= '0;
      done       <= 1'b0;
      res_valid  <= 1'b0;
      res_nonce  <= '0;
      res_ovf    <= 1'b0;
    end else begin
      dl   <= {dl[LATENCY-2:0], dl_in};
      done <= drain_last;

      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;

      if (accept) begin
        hash_state <= bus.work_midstate;
        tail_q     <= bus.work_tail;
        end_q      <= bus.work_nonce_end;
        issue_cnt  <= bus.work_nonce_start;
        retire_cnt <= bus.work_nonce_start;
        pad_en     <= 1'b1;
      end else begin
        // Counter parks on the last nonce so hash_data stays stable through the drain.
        if (state == S_ISSUE && issue_cnt != end_q) issue_cnt <= issue_cnt + 32'd1;
        if (retire) retire_cnt <= retire_cnt + 32'd1;
      end

      if (match) begin
        if (!res_valid || bus.result_ready) begin
          res_nonce <= retire_cnt;
          res_valid <= 1'b1;
        end
      end else if (bus.result_ready) begin
        res_valid <= 1'b0;
      end

      if (accept)                                          res_ovf <= 1'b0;
      else if (match && res_valid && !bus.result_ready)    res_ovf <= 1'b1;
    end
  end

`ifdef SHA256_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stat_hashes <= '0;
    else if (retire) stat_hashes <= stat_hashes + 48'd1;
  end
`endif

endmodule

// File: tb/tb_sha256_work_dispatcher.sv
// tb/tb_sha256_work_dispatcher.sv - directed bench for sha256_work_dispatcher with a behavioural core model
`timescale 1ns/1ps
module tb_sha256_work_dispatcher;
  localparam int          L  = 8;
  localparam logic [31:0] MV = 32'hA41F32E7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] hash_state;
  logic [511:0] hash_data;
  logic [31:0]  hash_midhash;
  logic         busy;
  logic         done;
`ifdef SHA256_DISPATCH_STATS_EN
  logic [47:0]  stat_hashes;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] m_a = 32'hDEAD0000;
  logic [31:0] m_b = 32'hDEAD0001;
  logic        m_all = 1'b0;
  logic [31:0] pipe [L];
  logic [95:0] tail_exp = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

  sha256_work_dispatcher_if bus();

  sha256_work_dispatcher #(.LATENCY(L), .MATCH_VALUE(MV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .hash_state(hash_state),
    .hash_data(hash_data),
    .hash_midhash(hash_midhash),
    .busy(busy),
    .done(done)
`ifdef SHA256_DISPATCH_STATS_EN
    ,
    .stat_hashes(stat_hashes)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: the nonce word seen L clocks ago decides hash_midhash; never reset.
  always @(posedge clk) begin
    pipe[0] <= hash_data[127:96];
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  always_comb begin
    if (m_all || pipe[L-1] === m_a || pipe[L-1] === m_b) hash_midhash = MV;
    else                                                 hash_midhash = pipe[L-1] ^ 32'h5555AAAA;
  end

  task automatic offer(input logic [31:0] s, input logic [31:0] e, output int t0);
    @(negedge clk);
    bus.work_midstate    = {8{s ^ 32'h6A09E667}};
    bus.work_tail        = tail_exp;
    bus.work_nonce_start = s;
    bus.work_nonce_end   = e;
    bus.work_valid       = 1'b1;
    @(posedge clk);
    #1;
    bus.work_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (bus.work_ready !== 1'b1)   begin bad++; $display("FAIL rst_work_ready got=%0b want=1", bus.work_ready); end
    total++; if (busy !== 1'b0)             begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0)             begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid got=%0b want=0", bus.result_valid); end
    total++; if (bus.result_nonce !== 32'h0) begin bad++; $display("FAIL rst_result_nonce got=%h want=0", bus.result_nonce); end
    total++; if (bus.result_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b want=0", bus.result_overflow); end
    total++; if (hash_state !== 256'h0)     begin bad++; $display("FAIL rst_hash_state got=%h want=0", hash_state); end
    total++; if (hash_data !== 512'h0)      begin bad++; $display("FAIL rst_hash_data got=%h want=0", hash_data); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.work_ready !== 1'b1)   begin bad++; $display("FAIL rst_release_ready got=%0b want=1", bus.work_ready); end
  endtask

  task automatic test_reset_mid_issue;
    int t0;
    int seen;
    m_a = 32'h2; m_b = 32'hDEAD0001; m_all = 1'b0;
    bus.result_ready = 1'b0;
    offer(32'h0, 32'd100, t0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.work_ready !== 1'b1)   begin bad++; $display("FAIL mid_work_ready got=%0b want=1", bus.work_ready); end
    total++; if (busy !== 1'b0)             begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL mid_result_valid got=%0b want=0", bus.result_valid); end
    total++; if (hash_state !== 256'h0)     begin bad++; $display("FAIL mid_hash_state got=%h want=0", hash_state); end
    total++; if (hash_data !== 512'h0)      begin bad++; $display("FAIL mid_hash_data got=%h want=0", hash_data); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 * L; i++) begin
      @(negedge clk);
      if (bus.result_valid || busy || done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_post_reset_activity got=%0d want=0", seen); end
    m_a = 32'hDEAD0000;
  endtask

  task automatic test_basic;
    int t0, rv_at, done_at, dn;
    logic [255:0] ms_exp;
    m_a = 32'h12; m_b = 32'hDEAD0001; m_all = 1'b0;
    bus.result_ready = 1'b0;
    ms_exp = {8{32'h10 ^ 32'h6A09E667}};
    offer(32'h10, 32'h13, t0);
    @(negedge clk);
    total++; if (hash_data[511:480] !== 32'h280)      begin bad++; $display("FAIL basic_word15 got=%h want=280", hash_data[511:480]); end
    total++; if (hash_data[159:128] !== 32'h80000000) begin bad++; $display("FAIL basic_word4 got=%h want=80000000", hash_data[159:128]); end
    total++; if (hash_data[479:160] !== 320'h0)       begin bad++; $display("FAIL basic_words5_14 got=%h want=0", hash_data[479:160]); end
    total++; if (hash_data[127:96] !== 32'h10)        begin bad++; $display("FAIL basic_word3 got=%h want=10", hash_data[127:96]); end
    total++; if (hash_data[95:0] !== tail_exp)        begin bad++; $display("FAIL basic_tail got=%h want=%h", hash_data[95:0], tail_exp); end
    total++; if (hash_state !== ms_exp)               begin bad++; $display("FAIL basic_state got=%h want=%h", hash_state, ms_exp); end
    total++; if (bus.work_ready !== 1'b0)             begin bad++; $display("FAIL basic_ready_busy got=%0b want=0", bus.work_ready); end
    rv_at = -1; done_at = -1; dn = 0;
    for (int i = 0; i < L + 12; i++) begin
      if (bus.result_valid && rv_at < 0) rv_at = cyc;
      if (done) begin dn++; if (done_at < 0) done_at = cyc; end
      @(negedge clk);
    end
    total++; if (rv_at - t0 !== L + 3)   begin bad++; $display("FAIL basic_result_latency got=%0d want=%0d", rv_at - t0, L + 3); end
    total++; if (done_at - t0 !== L + 4) begin bad++; $display("FAIL basic_done_latency got=%0d want=%0d", done_at - t0, L + 4); end
    total++; if (dn !== 1)               begin bad++; $display("FAIL basic_done_count got=%0d want=1", dn); end
    total++; if (bus.result_nonce !== 32'h12) begin bad++; $display("FAIL basic_result_nonce got=%h want=12", bus.result_nonce); end
    total++; if (bus.result_overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0b want=0", bus.result_overflow); end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%0b want=0", bus.result_valid); end
    m_a = 32'hDEAD0000;
  endtask

  task automatic test_wrap;
    int t0;
    logic [31:0] exp_n [4];
    logic [31:0] iss [4];
    logic [31:0] got [$];
    exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    m_all = 1'b1;
    bus.result_ready = 1'b1;
    offer(32'hFFFFFFFE, 32'h00000001, t0);
    for (int i = 0; i < L + 10; i++) begin
      @(negedge clk);
      if (cyc - t0 >= 0 && cyc - t0 < 4) iss[cyc - t0] = hash_data[127:96];
      if (bus.result_valid && bus.result_ready) got.push_back(bus.result_nonce);
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (iss[k] !== exp_n[k]) begin bad++; $display("FAIL wrap_issue%0d got=%h want=%h", k, iss[k], exp_n[k]); end
    end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL wrap_retire_count got=%0d want=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++; if (got[k] !== exp_n[k]) begin bad++; $display("FAIL wrap_result%0d got=%h want=%h", k, got[k], exp_n[k]); end
    end
    total++; if (bus.result_overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%0b want=0", bus.result_overflow); end
    m_all = 1'b0;
    bus.result_ready = 1'b0;
  endtask

  task automatic test_overflow;
    int t0;
    logic [31:0] got [$];
    m_a = 32'h5; m_b = 32'h6; m_all = 1'b0;
    bus.result_ready = 1'b0;
    offer(32'h4, 32'h7, t0);
    repeat (L + 10) @(negedge clk);
    total++; if (bus.result_valid !== 1'b1)    begin bad++; $display("FAIL ovf_valid got=%0b want=1", bus.result_valid); end
    total++; if (bus.result_nonce !== 32'h5)   begin bad++; $display("FAIL ovf_nonce got=%h want=5", bus.result_nonce); end
    total++; if (bus.result_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", bus.result_overflow); end
    bus.result_ready = 1'b1;
    offer(32'h4, 32'h7, t0);
    total++; if (bus.result_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_accept got=%0b want=0", bus.result_overflow); end
    for (int i = 0; i < L + 10; i++) begin
      @(negedge clk);
      if (bus.result_valid && bus.result_ready) got.push_back(bus.result_nonce);
    end
    total++; if (got.size() !== 2) begin bad++; $display("FAIL ovf_ready_count got=%0d want=2", got.size()); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 32'h5 || got[1] !== 32'h6) begin bad++; $display("FAIL ovf_ready_nonces got=%h,%h want=5,6", got[0], got[1]); end
    end
    total++; if (bus.result_overflow !== 1'b0) begin bad++; $display("FAIL ovf_ready_flag got=%0b want=0", bus.result_overflow); end
    bus.result_ready = 1'b0;
    m_a = 32'hDEAD0000; m_b = 32'hDEAD0001;
  endtask

  task automatic test_single;
    int t0, done_at, busy_cnt, bad_ready, bad_nonce;
    bus.result_ready = 1'b0;
    offer(32'h7, 32'h7, t0);
    bus.work_nonce_start = 32'h99;
    bus.work_nonce_end   = 32'h99;
    bus.work_valid       = 1'b1;
    done_at = -1; busy_cnt = 0; bad_ready = 0; bad_nonce = 0;
    for (int i = 0; i < L + 10 && done_at < 0; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (bus.work_ready !== 1'b0) bad_ready++;
        if (hash_data[127:96] !== 32'h7) bad_nonce++;
      end
      if (done) begin done_at = cyc; bus.work_valid = 1'b0; end
    end
    bus.work_valid = 1'b0;
    total++; if (busy_cnt !== L + 1)     begin bad++; $display("FAIL single_busy_cycles got=%0d want=%0d", busy_cnt, L + 1); end
    total++; if (bad_ready !== 0)        begin bad++; $display("FAIL single_ready_low got=%0d want=0", bad_ready); end
    total++; if (bad_nonce !== 0)        begin bad++; $display("FAIL single_nonce_held got=%0d want=0", bad_nonce); end
    total++; if (done_at - t0 !== L + 1) begin bad++; $display("FAIL single_done_latency got=%0d want=%0d", done_at - t0, L + 1); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || hash_data[127:96] !== 32'h7) begin bad++; $display("FAIL single_no_reaccept got=%0b/%h want=0/7", busy, hash_data[127:96]); end
  endtask

  task automatic test_stats;
`ifdef SHA256_DISPATCH_STATS_EN
    int t0;
    logic [47:0] base;
    @(negedge clk);
    base = stat_hashes;
    offer(32'h20, 32'h23, t0);
    repeat (L + 8) @(negedge clk);
    offer(32'h30, 32'h32, t0);
    repeat (L + 8) @(negedge clk);
    total++; if (stat_hashes !== base + 48'd7) begin bad++; $display("FAIL stats_count got=%0d want=%0d", stat_hashes, base + 48'd7); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.work_valid       = 1'b0;
    bus.work_midstate    = '0;
    bus.work_tail        = '0;
    bus.work_nonce_start = '0;
    bus.work_nonce_end   = '0;
    bus.result_ready     = 1'b0;
    test_reset();
    test_reset_mid_issue();
    test_basic();
    test_wrap();
    test_overflow();
    test_single();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
